usrt_trans: RTL and testbench
=============================

Name: usrt_trans

Overview:
Synchronous serial (USRT) transmitter, the send-side counterpart of the project's USRT receiver (`usrt_rec`). Bytes written by the calculator core are buffered in a small FIFO, then serialised on `tx`. Bit timing comes from the externally supplied bit clock `usrt_clk`, which is sampled in the `clk` domain. The line format is the one `usrt_rec` decodes: start bit, 8 data bits LSB first, optional parity, stop bit(s).

Parameters:
- DEPTH, 4, FIFO depth in bytes; must be a power of 2, minimum 2.
- STOP_BITS, 1, number of stop bits per frame; legal values 1 or 2.

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- usrt_clk  input  1  external bit clock, asynchronous to clk, period at least 8 clk cycles.
- data  input  8  byte to transmit.
- wr  input  1  write strobe; pushes `data` into the FIFO when `full`=0.
- full  output  1  FIFO full.
- tx  output  1  serial line; idles high.
- busy  output  1  high while a frame is in progress or the FIFO is non-empty.
- done  output  1  one-clk pulse at the end of each frame.

Behaviour:
- Reset:
  - One clk is a single rising edge of `clk` with `rst`=1.
  - Resulting values: `tx`=1, `full`=0, `busy`=0, `done`=0; FIFO emptied; state IDLE; synchroniser flops = 0.
  - Reset mid-frame aborts the frame: `tx` is 1 on the cycle after reset and the partial byte is discarded.
- usrt_clk synchronisation:
  - Two-flop synchroniser s1→s2, plus delay flop s3.
  - `fall` = s3 & ~s2; it is high for exactly one clk per falling edge.
  - Only `fall` advances the FSM, so `tx` changes on `usrt_clk` falling edges and is stable at `usrt_clk` rising edges, where the receiver samples.
  - Rising edges are ignored.
- FIFO:
  - Push when `wr` & ~`full`; a write while `full`=1 is dropped silently.
  - The count has log2(DEPTH)+1 bits and the pointers wrap modulo DEPTH.
  - Pop happens only on a START transition.
  - Push and pop in the same cycle leave the count unchanged.
  - A byte pushed into an empty FIFO becomes eligible at the next `fall`, never at a `fall` in the same cycle.
  - `full` is registered: it is high when count==DEPTH.
- FSM states: IDLE, START, DATA, PARITY, STOP. All transitions occur on a cycle with `fall`=1.
  - IDLE (`tx`=1): if the FIFO is non-empty, pop into the shift register, `tx`←0, go to START. Otherwise stay.
  - START: `tx`←shift[0], bit counter←0, go to DATA.
  - DATA: on each `fall`, shift right and drive the next bit.
    - After bit 7 has been held for one period, go to PARITY (macro on) or STOP with `tx`←1 (macro off).
  - PARITY: `tx`←1, go to STOP.
  - STOP: holds `tx`=1 for STOP_BITS periods, then at the final `fall`:
    - `done` pulses for that one clk;
    - if the FIFO is non-empty, pop, `tx`←0, go to START (back-to-back frames, no idle bit);
    - else go to IDLE.
- Latency:
  - `tx` changes on the clk edge where `fall`=1, i.e. 3 clk after the `usrt_clk` falling edge at the synchroniser input.
  - Each line bit lasts exactly one `usrt_clk` period.
- `busy` = (state≠IDLE) | (count≠0), registered alongside the state.
- If `usrt_clk` stops, the FSM freezes in its current state with `tx` held; no timeout.

Optional Feature:
- Macro: USRT_TRANS_PARITY_EN.
- Defined: the PARITY state is compiled in and driven one period after bit 7. The parity bit is even parity (XOR of the 8 data bits), latched at pop. Frame = 10+STOP_BITS bit periods.
- Undefined: no PARITY state and no parity logic; DATA goes straight to STOP. Frame = 9+STOP_BITS periods.

Test Plan:
- Basic frame:
  - Stimulus: reset, then write 0xA5, STOP_BITS=1, macro off, toggle `usrt_clk` at 20 ns half-period.
  - Expected `tx` at successive rising edges: 0,1,0,1,0,0,1,0,1,1.
  - Then `done` pulses once, `busy` falls, `tx` stays 1.
- Parity:
  - With the macro on, 0xA5 → parity bit 0 before the stop bit.
  - With the macro on, 0x07 → parity bit 1 before the stop bit.
- FIFO full:
  - `usrt_clk` held low; write 0x11,0x22,0x33,0x44,0x55.
  - `full`=1 after the 4th write; 0x55 is dropped.
  - Restart `usrt_clk`: four back-to-back frames 0x11..0x44, no idle bits between them, four `done` pulses.
- Push during transmit:
  - Write 0x3C while 0x11 is in DATA.
  - 0x3C starts at the `fall` ending 0x11's stop bit; `busy` stays 1 throughout.
- Reset mid-frame:
  - Assert `rst` during DATA bit 4 with 2 bytes queued.
  - Next cycle: `tx`=1, `busy`=0, `full`=0.
  - No `done` pulse, no further frames.
- STOP_BITS=2:
  - Write 0xFF.
  - `tx` low for exactly 1 period, then high for 10 periods; `done` pulses at the end of the 2nd stop period.

Source files
------------

// File: rtl/usrt_trans.sv
`timescale 1ns/1ps
// USRT transmitter: FIFO-buffered bytes sent as start, 8 data bits LSB first, optional even parity
// (macro USRT_TRANS_PARITY_EN), then STOP_BITS stop bits. Latency: tx moves 3 clk after a usrt_clk fall.
// Backpressure: full is registered and asserted at count==DEPTH; writes while full are dropped.
module usrt_trans #(
    parameter int DEPTH     = 4,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       usrt_clk,
    input  logic [7:0] data,
    input  logic       wr,
    output logic       full,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

`ifdef USRT_TRANS_PARITY_EN
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

    logic          s1_q, s2_q, s3_q;
    logic          fall;
    state_t        state_q;
    logic [7:0]    shift_q;
    logic [2:0]    bit_cnt_q;
    logic          stop_cnt_q;
    logic          stop_last;
    logic          tx_q, done_q, busy_q;
`ifdef USRT_TRANS_PARITY_EN
    logic          parity_q;
`endif

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          full_q;
    logic          push, pop, idle_next;

    assign fall      = s3_q & ~s2_q;
    assign stop_last = (STOP_BITS == 1) || stop_cnt_q;
    assign push      = wr & ~full_q;
    // count_q (not count_d) gates the pop, so a byte written this cycle waits for the next fall
    assign pop       = fall & (count_q != '0) &
                       ((state_q == S_IDLE) | ((state_q == S_STOP) & stop_last));
    assign idle_next = ~pop & ((state_q == S_IDLE) | (fall & (state_q == S_STOP) & stop_last));

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
            s3_q <= 1'b0;
        end else begin
            s1_q <= usrt_clk;
            s2_q <= s1_q;
            s3_q <= s2_q;
        end
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            full_q   <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
            full_q  <= (count_d == CW'(DEPTH));
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            shift_q    <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            tx_q       <= 1'b1;
            done_q     <= 1'b0;
            busy_q     <= 1'b0;
`ifdef USRT_TRANS_PARITY_EN
            parity_q   <= 1'b0;
`endif
        end else begin
            done_q <= fall & (state_q == S_STOP) & stop_last;
            busy_q <= ~idle_next | (count_d != '0);
            if (pop) begin
                // back-to-back frames reload here straight from STOP with no idle bit
                shift_q <= mem_q[rd_ptr_q];
`ifdef USRT_TRANS_PARITY_EN
                parity_q <= ^mem_q[rd_ptr_q];
`endif
                tx_q    <= 1'b0;
                state_q <= S_START;
            end else if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        tx_q <= 1'b1;
                    end
                    S_START: begin
                        tx_q      <= shift_q[0];
                        shift_q   <= {1'b0, shift_q[7:1]};
                        bit_cnt_q <= '0;
                        state_q   <= S_DATA;
                    end
                    S_DATA: begin
                        if (bit_cnt_q == 3'd7) begin
`ifdef USRT_TRANS_PARITY_EN
                            tx_q    <= parity_q;
                            state_q <= S_PARITY;
`else
                            tx_q       <= 1'b1;
                            stop_cnt_q <= 1'b0;
                            state_q    <= S_STOP;
`endif
                        end else begin
                            tx_q      <= shift_q[0];
                            shift_q   <= {1'b0, shift_q[7:1]};
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
`ifdef USRT_TRANS_PARITY_EN
                    S_PARITY: begin
                        tx_q       <= 1'b1;
                        stop_cnt_q <= 1'b0;
                        state_q    <= S_STOP;
                    end
`endif
                    S_STOP: begin
                        if (stop_last) state_q    <= S_IDLE;
                        else           stop_cnt_q <= 1'b1;
                    end
                    default: begin
                        tx_q    <= 1'b1;
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign full = full_q;
    assign tx   = tx_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_usrt_trans.sv
`timescale 1ns/1ps
// Bench for usrt_trans: line-level frame model checked at every usrt_clk rising edge,
// plus literal frame vectors for the main DUT (STOP_BITS=1) and a STOP_BITS=2 instance.
module tb_usrt_trans;

    localparam int DEPTH = 4;
`ifdef USRT_TRANS_PARITY_EN
    localparam int FR = 11;
`else
    localparam int FR = 10;
`endif

    logic       clk = 1'b0;
    logic       rst, usrt_clk;
    logic [7:0] data, data2;
    logic       wr, wr2;
    logic       full, tx, busy, done;
    logic       full2, tx2, busy2, done2;

    always #2 clk = ~clk;

    usrt_trans #(.DEPTH(DEPTH), .STOP_BITS(1)) dut (
        .clk(clk), .rst(rst), .usrt_clk(usrt_clk), .data(data), .wr(wr),
        .full(full), .tx(tx), .busy(busy), .done(done)
    );

    usrt_trans #(.DEPTH(DEPTH), .STOP_BITS(2)) dut2 (
        .clk(clk), .rst(rst), .usrt_clk(usrt_clk), .data(data2), .wr(wr2),
        .full(full2), .tx(tx2), .busy(busy2), .done(done2)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Line model: pending bytes and the bit sequence of the frame on the wire
    byte unsigned mq[$];
    bit           fb[$];
    bit           exp_line = 1'b1;
    bit           in_frame = 1'b0;
    int           exp_done = 0;
    int           done_cnt = 0;
    int           done2_cnt = 0;
    bit           line_log[$];
    bit           line2_log[$];
    bit           uclk_run = 1'b0;

    task automatic model_push(input logic [7:0] d);
        if (mq.size() < DEPTH) mq.push_back(d);
    endtask

    task automatic model_reset();
        mq.delete();
        fb.delete();
        exp_line = 1'b1;
        in_frame = 1'b0;
    endtask

    task automatic model_fall();
        logic [7:0] d;
        if (in_frame && fb.size() > 0) begin
            exp_line = fb.pop_front();
        end else begin
            if (in_frame) begin
                exp_done++;
                in_frame = 1'b0;
            end
            if (mq.size() > 0) begin
                d = mq.pop_front();
                fb.delete();
                fb.push_back(1'b0);
                for (int i = 0; i < 8; i++) fb.push_back(d[i]);
`ifdef USRT_TRANS_PARITY_EN
                fb.push_back(^d);
`endif
                fb.push_back(1'b1);
                exp_line = fb.pop_front();
                in_frame = 1'b1;
            end else begin
                exp_line = 1'b1;
            end
        end
    endtask

    // usrt_clk: 20 ns half-period (5 clk), edges placed on clk falling edges
    initial begin
        usrt_clk = 1'b0;
        forever begin
            @(negedge clk);
            if (uclk_run) begin
                usrt_clk = 1'b1;
                repeat (5) @(negedge clk);
                usrt_clk = 1'b0;
                model_fall();
                repeat (4) @(negedge clk);
            end
        end
    end

    always @(negedge clk) begin
        if (done === 1'b1)  done_cnt++;
        if (done2 === 1'b1) done2_cnt++;
    end

    // Compare process: receiver sample point is the usrt_clk rising edge
    always @(posedge usrt_clk) begin
        check("tx_vs_model",   tx,   exp_line);
        check("busy_vs_model", busy, in_frame || mq.size() > 0);
        check("full_vs_model", full, mq.size() == DEPTH);
        check("done_count",    done_cnt, exp_done);
        line_log.push_back(tx);
        line2_log.push_back(tx2);
    end

    task automatic wr1(input logic [7:0] d);
        check("full_before_wr", full, mq.size() == DEPTH);
        data = d;
        wr   = 1'b1;
        model_push(d);
        @(negedge clk);
        wr = 1'b0;
    endtask

    task automatic wait_rises(input int n);
        repeat (n) @(posedge usrt_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
`ifdef USRT_TRANS_PARITY_EN
        logic [0:10] e_a5 = 11'b0_10100101_0_1;
        logic [0:11] e_ff = 12'b0_11111111_0_11;
`else
        logic [0:9]  e_a5 = 10'b0_10100101_1;
        logic [0:10] e_ff = 11'b0_11111111_11;
`endif
        rst = 1'b1; wr = 1'b0; data = '0; wr2 = 1'b0; data2 = '0;
        repeat (3) @(negedge clk);
        check("rst_tx", tx, 1);
        check("rst_full", full, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_tx2", tx2, 1);
        check("rst_busy2", busy2, 0);
        rst = 1'b0;
        uclk_run = 1'b1;

        // Basic frame 0xA5
        wait_rises(2);
        @(negedge clk);
        line_log.delete();
        wr1(8'hA5);
        wait_rises(FR);
        for (int i = 0; i < FR; i++) check("a5_bit", line_log[i], e_a5[i]);
        wait_rises(1);
        check("a5_done_once", done_cnt, 1);
        check("a5_busy_low", busy, 0);
        check("a5_tx_idle", tx, 1);

        // 0x07: bit 3 is the first 0; bit after data is parity 1 or stop 1
        @(negedge clk);
        line_log.delete();
        wr1(8'h07);
        wait_rises(FR);
        check("b07_start", line_log[0], 0);
        check("b07_bit2", line_log[3], 1);
        check("b07_bit3", line_log[4], 0);
        check("b07_after_data", line_log[9], 1);
        wait_rises(2);

        // Push during transmit: 0x3C starts right after 0x11's stop bit
        @(negedge clk);
        line_log.delete();
        wr1(8'h11);
        wait_rises(3);
        @(negedge clk);
        wr1(8'h3C);
        wait_rises(FR - 2);
        check("b2b_stop_11", line_log[FR-1], 1);
        check("b2b_start_3c", line_log[FR], 0);
        wait_rises(FR + 1);
        check("b2b_busy_end", busy, 0);

        // FIFO full with usrt_clk stopped
        wait_rises(1);
        uclk_run = 1'b0;
        repeat (15) @(negedge clk);
        wr1(8'h11); wr1(8'h22); wr1(8'h33);
        check("full_after_3", full, 0);
        wr1(8'h44);
        check("full_after_4", full, 1);
        wr1(8'h55);
        check("full_after_5", full, 1);
        check("busy_stopped", busy, 1);
        base = done_cnt;
        line_log.delete();
        uclk_run = 1'b1;
        wait_rises(2 + 4 * FR);
        check("full_frames_done", done_cnt - base, 4);
        for (int k = 0; k < 4; k++) check("full_frame_start", line_log[1 + k * FR], 0);
        check("full_22_bit1", line_log[1 + FR + 2], 1);
        check("full_idle_after", line_log[1 + 4 * FR], 1);
        check("full_cleared", full, 0);

        // Reset during DATA bit 4 with two bytes queued
        @(negedge clk);
        wr1(8'hA1); wr1(8'hB2); wr1(8'hC3);
        wait_rises(6);
        @(negedge clk);
        rst = 1'b1;
        model_reset();
        base = done_cnt;
        @(negedge clk);
        check("midrst_tx", tx, 1);
        check("midrst_busy", busy, 0);
        check("midrst_full", full, 0);
        rst = 1'b0;
        wait_rises(3 * FR);
        check("midrst_no_done", done_cnt, base);
        check("midrst_idle", tx, 1);

        // STOP_BITS=2 instance, 0xFF
        @(negedge clk);
        line2_log.delete();
        data2 = 8'hFF;
        wr2   = 1'b1;
        @(negedge clk);
        wr2 = 1'b0;
        wait_rises(FR + 1);
        for (int i = 0; i <= FR; i++) check("ff_sb2_bit", line2_log[i], e_ff[i]);
        check("ff_sb2_no_done_yet", done2_cnt, 0);
        check("ff_sb2_busy", busy2, 1);
        wait_rises(1);
        check("ff_sb2_done", done2_cnt, 1);
        check("ff_sb2_busy_low", busy2, 0);
        check("ff_sb2_tx_idle", tx2, 1);
        check("ff_sb2_full", full2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
